// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcode constants,
// fetch FSM state encoding and the default reset vector.
package mips_pkg;

    // Primary opcodes (Instr[31:26]) recognised by main_decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // Word-aligned PC value loaded on reset
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // One-hot fetch FSM encoding
    typedef enum logic [1:0] {
        ST_FETCH = 2'b01,
        ST_ISSUE = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC computation: sequential, beq target or jump target.
// Jump takes priority over a taken branch.
module next_pc_logic (
    input  logic [31:0] i_pc,
    input  logic [25:0] i_instr_idx,
    input  logic        i_pcsrc,
    input  logic        i_jmp,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_next_pc
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;

    // Sequential address and both redirect candidates; all adds wrap mod 2^32
    assign w_pc_plus4      = i_pc + 32'd4;
    assign w_branch_off    = {{14{i_instr_idx[15]}}, i_instr_idx[15:0], 2'b00};
    assign w_branch_target = w_pc_plus4 + w_branch_off;
    assign w_jump_target   = {w_pc_plus4[31:28], i_instr_idx, 2'b00};

    // Priority select: jump, then taken branch, then fall-through
    always_comb begin
        o_next_pc = w_pc_plus4;
        if (i_jmp) begin
            o_next_pc = w_jump_target;
        end else if (i_pcsrc) begin
            o_next_pc = w_branch_target;
        end
    end

    assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over
// a req/ready handshake and holds it until the datapath commits.
// Optional macro FETCH_PERF_EN adds RetiredCount / WaitCycles counters.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          CNT_WIDTH    = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    output logic                 IMemReq,
    output logic [31:0]          IMemAddr,
    input  logic                 IMemReady,
    input  logic [31:0]          IMemRData,
    output logic [31:0]          Instr,
    output logic                 InstrValid,
    output logic [31:0]          PC,
    output logic [31:0]          PCPlus4,
    input  logic                 PCSrc,
    input  logic                 Jmp,
    input  logic                 Commit
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] RetiredCount,
    output logic [CNT_WIDTH-1:0] WaitCycles
`endif
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_instr_valid;
    logic [31:0]  w_next_pc;
    logic [31:0]  w_pc_plus4;

    next_pc_logic u_next_pc (
        .i_pc        (r_pc),
        .i_instr_idx (r_instr[25:0]),
        .i_pcsrc     (PCSrc),
        .i_jmp       (Jmp),
        .o_pc_plus4  (w_pc_plus4),
        .o_next_pc   (w_next_pc)
    );

    // FSM: fetch until memory accepts, then hold the word until Commit advances the PC
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_VECTOR;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (IMemReady) begin
                        r_instr       <= IMemRData;
                        r_instr_valid <= 1'b1;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (Commit) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_FETCH;
                    end
                end
                default: begin
                    r_state       <= ST_FETCH;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] r_retired_count;
    logic [CNT_WIDTH-1:0] r_wait_cycles;

    // Free-running wrap-around counters of accepted commits and stalled fetch cycles
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_retired_count <= '0;
            r_wait_cycles   <= '0;
        end else begin
            if (r_state == ST_ISSUE && Commit) begin
                r_retired_count <= r_retired_count + CNT_ONE;
            end
            if (r_state == ST_FETCH && !IMemReady) begin
                r_wait_cycles <= r_wait_cycles + CNT_ONE;
            end
        end
    end

    assign RetiredCount = r_retired_count;
    assign WaitCycles   = r_wait_cycles;
`else
    // Counter width only matters when the counters are built
    logic w_unused_cnt_width;
    assign w_unused_cnt_width = (CNT_WIDTH > 0);
`endif

    // Request is a pure decode of state; address always tracks the PC
    assign IMemReq    = (r_state == ST_FETCH);
    assign IMemAddr   = r_pc;
    assign PC         = r_pc;
    assign PCPlus4    = w_pc_plus4;
    assign Instr      = r_instr;
    assign InstrValid = r_instr_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch addresses
// and committed instructions; a negedge monitor pops and compares.
module tb_fetch_unit;
    import mips_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } commit_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemRData;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        PCSrc;
    logic        Jmp;
    logic        Commit;
`ifdef FETCH_PERF_EN
    logic [31:0] RetiredCount;
    logic [31:0] WaitCycles;
`endif

    logic [31:0] q_fetch[$];
    commit_t     q_commit[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_retired = 0;
    int          exp_waits = 0;
    logic [31:0] cur_pc;
    logic [31:0] cur_word;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK        (CLK),
        .RST        (RST),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemReady  (IMemReady),
        .IMemRData  (IMemRData),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .PCSrc      (PCSrc),
        .Jmp        (Jmp),
        .Commit     (Commit)
`ifdef FETCH_PERF_EN
        ,
        .RetiredCount (RetiredCount),
        .WaitCycles   (WaitCycles)
`endif
    );

    function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] j_instr(logic [25:0] target);
        return {OP_J, target};
    endfunction

    function automatic logic [31:0] beq_instr(logic [15:0] imm);
        return {OP_BEQ, 5'd1, 5'd2, imm};
    endfunction

    // Non-branch instruction with a nonzero immediate, so a wrongly taken branch shows
    function automatic logic [31:0] addi_instr();
        return {OP_ADDI, 5'd0, 5'd3, 16'h1234};
    endfunction

    // Monitor: compare every accepted fetch and every commit against the scoreboard
    always @(negedge CLK) begin
        logic [31:0] e_addr;
        commit_t     e_c;
        if (!RST && IMemReq && IMemReady) begin
            if (q_fetch.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL fetch_unexpected: got addr %h, expected no fetch", IMemAddr);
            end else begin
                e_addr = q_fetch.pop_front();
                $display("fetch   addr=%h expected=%h", IMemAddr, e_addr);
                chk32("fetch_addr", IMemAddr, e_addr);
            end
        end
        if (!RST && Commit && InstrValid) begin
            if (q_commit.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL commit_unexpected: got pc %h, expected no commit", PC);
            end else begin
                e_c = q_commit.pop_front();
                $display("commit  pc=%h instr=%h expected pc=%h instr=%h", PC, Instr, e_c.pc, e_c.instr);
                chk32("commit_instr", Instr, e_c.instr);
                chk32("commit_pc", PC, e_c.pc);
                chk32("commit_pcplus4", PCPlus4, e_c.pc + 32'd4);
            end
        end
    end

    // Fetch at addr with 'waits' not-ready cycles first; Commit may be asserted while stalled
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word,
                            input int waits, input logic commit_in_wait);
        cur_pc    = addr;
        cur_word  = word;
        IMemRData = word;
        for (int i = 0; i < waits; i++) begin
            IMemReady = 1'b0;
            Commit    = commit_in_wait;
            Jmp       = commit_in_wait;
            chk1("wait_req", IMemReq, 1'b1);
            chk32("wait_addr", IMemAddr, addr);
            chk1("wait_valid", InstrValid, 1'b0);
            exp_waits++;
            @(posedge CLK);
            #1;
        end
        Commit    = 1'b0;
        Jmp       = 1'b0;
        q_fetch.push_back(addr);
        IMemReady = 1'b1;
        @(posedge CLK);
        #1;
        IMemReady = 1'b0;
        IMemRData = 32'hDEAD_BEEF;
        chk1("issue_req", IMemReq, 1'b0);
        chk1("issue_valid", InstrValid, 1'b1);
    endtask

    task automatic do_commit(input logic pcsrc, input logic jmp);
        q_commit.push_back({cur_word, cur_pc});
        PCSrc  = pcsrc;
        Jmp    = jmp;
        Commit = 1'b1;
        exp_retired++;
        @(posedge CLK);
        #1;
        Commit = 1'b0;
        PCSrc  = 1'b0;
        Jmp    = 1'b0;
        chk1("post_commit_valid", InstrValid, 1'b0);
        chk1("post_commit_req", IMemReq, 1'b1);
    endtask

    initial begin
        RST       = 1'b1;
        IMemReady = 1'b0;
        IMemRData = 32'h0;
        PCSrc     = 1'b0;
        Jmp       = 1'b0;
        Commit    = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state
        chk1("reset_req", IMemReq, 1'b1);
        chk32("reset_pc", PC, 32'h0);
        chk32("reset_addr", IMemAddr, 32'h0);
        chk1("reset_valid", InstrValid, 1'b0);
        chk32("reset_instr", Instr, 32'h0);

        // Sequential run 0,4,8; jump to 0x10
        do_fetch(32'h0000_0000, addi_instr(), 0, 1'b0);  do_commit(1'b0, 1'b0);
        do_fetch(32'h0000_0004, addi_instr(), 0, 1'b0);  do_commit(1'b0, 1'b0);
        do_fetch(32'h0000_0008, j_instr(26'h4), 0, 1'b0); do_commit(1'b0, 1'b1);
        // Three stall cycles at 0x10, with Commit (ignored) during the stall
        do_fetch(32'h0000_0010, addi_instr(), 3, 1'b1);  do_commit(1'b0, 1'b0);
        do_fetch(32'h0000_0014, j_instr(26'h40), 0, 1'b0); do_commit(1'b0, 1'b1);
        // Backward branch 0x100 -> 0xFC, jump back, forward branch -> 0x110
        do_fetch(32'h0000_0100, beq_instr(16'hFFFE), 0, 1'b0); do_commit(1'b1, 1'b0);
        do_fetch(32'h0000_00FC, j_instr(26'h40), 0, 1'b0);     do_commit(1'b0, 1'b1);
        do_fetch(32'h0000_0100, beq_instr(16'h0003), 0, 1'b0); do_commit(1'b1, 1'b0);
        // Jmp and PCSrc together: jump wins (0x200, not branch 0x314)
        do_fetch(32'h0000_0110, {OP_J, 26'h0000080}, 0, 1'b0); do_commit(1'b1, 1'b1);
        // Branch-format word with PCSrc=0 falls through
        do_fetch(32'h0000_0200, beq_instr(16'h0040), 0, 1'b0); do_commit(1'b0, 1'b0);
        // Branch offset wraps below zero: 0x208 - 0x214 = 0xFFFF_FFF4
        do_fetch(32'h0000_0204, beq_instr(16'hFF7B), 0, 1'b0); do_commit(1'b1, 1'b0);
        // Jump keeps PCPlus4[31:28] = 4'hF
        do_fetch(32'hFFFF_FFF4, j_instr(26'h40), 0, 1'b0);     do_commit(1'b0, 1'b1);
        do_fetch(32'hF000_0100, j_instr(26'h3FF_FFFF), 0, 1'b0); do_commit(1'b0, 1'b1);
        // Sequential wrap 0xFFFF_FFFC -> 0
        do_fetch(32'hFFFF_FFFC, addi_instr(), 0, 1'b0);        do_commit(1'b0, 1'b0);

`ifdef FETCH_PERF_EN
        chk32("retired_count", RetiredCount, 32'(exp_retired));
        chk32("wait_cycles", WaitCycles, 32'(exp_waits));
`endif

        // Reset and Commit in the same cycle: reset wins
        do_fetch(32'h0000_0000, beq_instr(16'h0010), 0, 1'b0);
        RST    = 1'b1;
        Commit = 1'b1;
        PCSrc  = 1'b1;
        @(posedge CLK);
        #1;
        RST    = 1'b0;
        Commit = 1'b0;
        PCSrc  = 1'b0;
        exp_retired = 0;
        exp_waits   = 0;
        chk32("rst_commit_pc", PC, 32'h0);
        chk1("rst_commit_valid", InstrValid, 1'b0);
        chk32("rst_commit_instr", Instr, 32'h0);
        chk1("rst_commit_req", IMemReq, 1'b1);
`ifdef FETCH_PERF_EN
        chk32("retired_after_rst", RetiredCount, 32'h0);
        chk32("waits_after_rst", WaitCycles, 32'h0);
`endif

        // Five commits with two stall cycles
        do_fetch(32'h0000_0000, addi_instr(), 0, 1'b0); do_commit(1'b0, 1'b0);
        do_fetch(32'h0000_0004, addi_instr(), 2, 1'b0); do_commit(1'b0, 1'b0);
        do_fetch(32'h0000_0008, addi_instr(), 0, 1'b0); do_commit(1'b0, 1'b0);
        do_fetch(32'h0000_000C, addi_instr(), 0, 1'b0); do_commit(1'b0, 1'b0);
        do_fetch(32'h0000_0010, addi_instr(), 0, 1'b0); do_commit(1'b0, 1'b0);
`ifdef FETCH_PERF_EN
        chk32("retired_five", RetiredCount, 32'd5);
        chk32("waits_two", WaitCycles, 32'd2);
`endif

        // Reset while a fetch at 0x14 is stalled
        chk32("pre_rst_addr", IMemAddr, 32'h0000_0014);
        IMemReady = 1'b0;
        RST       = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk32("rst_fetch_pc", PC, 32'h0);
        chk32("rst_fetch_addr", IMemAddr, 32'h0);
        chk1("rst_fetch_req", IMemReq, 1'b1);

        // Fetch restarts cleanly at the reset vector
        do_fetch(32'h0000_0000, addi_instr(), 0, 1'b0); do_commit(1'b0, 1'b0);
        chk32("final_pc", PC, 32'h0000_0004);

        repeat (2) @(posedge CLK);
        #1;
        chk32("fetch_queue_empty", 32'(q_fetch.size()), 32'h0);
        chk32("commit_queue_empty", 32'(q_commit.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
